// File: rtl/rgb_stream_packer.sv
// rgb_stream_packer: packs 24-bit RGB pixels four-into-three onto 32-bit AXI4-Stream
// words, marks frame start/line end, and zero-pads partial words on misaligned markers.
module rgb_stream_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        valid,
  input  logic        sof,
  input  logic        eol,
  output logic        in_ready,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tlast,
  output logic        out_stream_tuser,
  output logic        out_stream_tvalid,
  input  logic        out_stream_tready,
  output logic        misalign
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic        user;
    logic        last;
    logic [31:0] data;
  } word_t;

  word_t          mem_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic [1:0]     phase_q, phase_d;
  logic [23:0]    carry_q, carry_d;
  logic           pend_q, pend_d;
  logic           misalign_q, misalign_d;
  logic           ready_q;

  logic [23:0] pix;
  logic        accept, pop, push0, push1, has_word, sof_pend;
  logic [1:0]  ph;
  word_t       w0, w1, nw, head;

  assign pix    = {r, g, b};
  assign accept = valid && in_ready;
  assign pop    = out_stream_tvalid && out_stream_tready;

  // A misaligned sof flushes the carry first (push0), then the pixel word follows (push1).
  always_comb begin
    phase_d    = phase_q;
    carry_d    = carry_q;
    pend_d     = pend_q;
    misalign_d = misalign_q;
    push0      = 1'b0;
    push1      = 1'b0;
    w0         = '0;
    w1         = '0;
    nw         = '0;
    has_word   = 1'b0;
    ph         = phase_q;
    sof_pend   = pend_q;
    if (accept) begin
      sof_pend = pend_q | sof;
      if (sof && phase_q != 2'd0) begin
        misalign_d = 1'b1;
        push0      = 1'b1;
        w0.last    = 1'b1;
        ph         = 2'd0;
        case (phase_q)
          2'd1:    w0.data = {8'h0, carry_q};
          2'd2:    w0.data = {16'h0, carry_q[15:0]};
          default: w0.data = {24'h0, carry_q[7:0]};
        endcase
      end
      if (eol && ph != 2'd3) misalign_d = 1'b1;
      case (ph)
        2'd0: begin
          if (eol) begin
            nw.data  = {8'h0, pix};
            has_word = 1'b1;
          end else begin
            carry_d = pix;
          end
        end
        2'd1: begin
          nw.data  = {pix[7:0], carry_q};
          carry_d  = {8'h0, pix[23:8]};
          has_word = 1'b1;
        end
        2'd2: begin
          nw.data  = {pix[15:0], carry_q[15:0]};
          carry_d  = {16'h0, pix[23:16]};
          has_word = 1'b1;
        end
        default: begin
          nw.data  = {pix, carry_q[7:0]};
          has_word = 1'b1;
        end
      endcase
      phase_d = eol ? 2'd0 : ph + 2'd1;
      pend_d  = sof_pend;
      if (has_word) begin
        nw.user = sof_pend;
        nw.last = eol;
        pend_d  = 1'b0;
      end
      if (push0) begin
        push1 = has_word;
        w1    = nw;
      end else begin
        push0 = has_word;
        w0    = nw;
      end
    end
  end

  assign count_d = count_q + CW'(push0) + CW'(push1) - CW'(pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= 2'd0;
      carry_q    <= '0;
      pend_q     <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      carry_q    <= carry_d;
      pend_q     <= pend_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_q + PW'(push0) + PW'(push1);
      rd_ptr_q   <= rd_ptr_q + PW'(pop);
      ready_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push0) mem_q[wr_ptr_q] <= w0;
    if (push1) mem_q[wr_ptr_q + PW'(1)] <= w1;
  end

  // Threshold leaves room for a two-word push on any accepted pixel.
  assign in_ready = ready_q && (count_q <= CW'(FIFO_DEPTH - 2));

  assign head              = mem_q[rd_ptr_q];
  assign out_stream_tvalid = (count_q != '0);
  assign out_stream_tdata  = out_stream_tvalid ? head.data : 32'h0;
  assign out_stream_tlast  = out_stream_tvalid && head.last;
  assign out_stream_tuser  = out_stream_tvalid && head.user;
  assign out_stream_tkeep  = 4'hF;
  assign misalign          = misalign_q;

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Directed testbench for rgb_stream_packer: per-pixel vector table with expected
// pushed words, plus sequences for backpressure, double push and async reset.
module tb_rgb_stream_packer;

  typedef struct packed {
    logic        user;
    logic        last;
    logic [31:0] data;
  } word_t;

  typedef struct {
    logic [23:0] pix;
    logic        sof;
    logic        eol;
    int          npush;
    word_t       w0;
    word_t       w1;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  r = '0, g = '0, b = '0;
  logic        valid = 1'b0, sof = 1'b0, eol = 1'b0;
  logic        in_ready;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tuser, tvalid;
  logic        tready = 1'b1;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  vec_t  tv [23];
  word_t cap_q [$];
  word_t exp_q [$];
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data = '0;

  rgb_stream_packer #(.FIFO_DEPTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .r                 (r),
    .g                 (g),
    .b                 (b),
    .valid             (valid),
    .sof               (sof),
    .eol               (eol),
    .in_ready          (in_ready),
    .out_stream_tdata  (tdata),
    .out_stream_tkeep  (tkeep),
    .out_stream_tlast  (tlast),
    .out_stream_tuser  (tuser),
    .out_stream_tvalid (tvalid),
    .out_stream_tready (tready),
    .misalign          (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic word_t mk(input logic u, input logic l, input logic [31:0] d);
    word_t w;
    w.user = u;
    w.last = l;
    w.data = d;
    return w;
  endfunction

  function automatic vec_t v(input logic [23:0] p, input logic s, input logic e,
                             input int n, input word_t a, input word_t c);
    vec_t x;
    x.pix = p; x.sof = s; x.eol = e; x.npush = n; x.w0 = a; x.w1 = c;
    return x;
  endfunction

  // Output monitor: captures popped words and checks data holds while stalled.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && tvalid) chk("stall_hold", tdata, stall_data);
      if (tvalid && tready) cap_q.push_back({tuser, tlast, tdata});
      stall_prev = tvalid && !tready;
      stall_data = tdata;
    end
  end

  task automatic send_vec(input int i);
    int t;
    r = tv[i].pix[23:16];
    g = tv[i].pix[15:8];
    b = tv[i].pix[7:0];
    sof = tv[i].sof;
    eol = tv[i].eol;
    valid = 1'b1;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("in_ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    if (tv[i].npush > 0) exp_q.push_back(tv[i].w0);
    if (tv[i].npush > 1) exp_q.push_back(tv[i].w1);
  endtask

  task automatic idle();
    valid = 1'b0;
    sof = 1'b0;
    eol = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic check_output(input string nm);
    int t;
    t = 0;
    while (cap_q.size() < exp_q.size() && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    chk({nm, "_count"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < cap_q.size()) chk($sformatf("%s_w%0d", nm, i), cap_q[i], exp_q[i]);
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // aligned frame
    tv[0]  = v(24'h102030, 1, 0, 0, '0, '0);
    tv[1]  = v(24'h112131, 0, 0, 1, mk(1, 0, 32'h31102030), '0);
    tv[2]  = v(24'h122232, 0, 0, 1, mk(0, 0, 32'h22321121), '0);
    tv[3]  = v(24'h132333, 0, 0, 1, mk(0, 0, 32'h13233312), '0);
    tv[4]  = v(24'h142434, 0, 0, 0, '0, '0);
    tv[5]  = v(24'h152535, 0, 0, 1, mk(0, 0, 32'h35142434), '0);
    tv[6]  = v(24'h162636, 0, 0, 1, mk(0, 0, 32'h26361525), '0);
    tv[7]  = v(24'h172737, 0, 1, 1, mk(0, 1, 32'h17273716), '0);
    // misaligned eol at phase 1, then an aligned line
    tv[8]  = v(24'hA1A2A3, 1, 0, 0, '0, '0);
    tv[9]  = v(24'hB1B2B3, 0, 1, 1, mk(1, 1, 32'hB3A1A2A3), '0);
    tv[10] = v(24'h030201, 0, 0, 0, '0, '0);
    tv[11] = v(24'h060504, 0, 0, 1, mk(0, 0, 32'h04030201), '0);
    tv[12] = v(24'h090807, 0, 0, 1, mk(0, 0, 32'h08070605), '0);
    tv[13] = v(24'h0C0B0A, 0, 1, 1, mk(0, 1, 32'h0C0B0A09), '0);
    // misaligned sof at phase 2
    tv[14] = v(24'h112233, 1, 0, 0, '0, '0);
    tv[15] = v(24'h445566, 0, 0, 1, mk(1, 0, 32'h66112233), '0);
    tv[16] = v(24'h778899, 1, 0, 1, mk(0, 1, 32'h00004455), '0);
    tv[17] = v(24'hAABBCC, 0, 1, 1, mk(1, 1, 32'hCC778899), '0);
    // double push: sof+eol at phase 1 with two words queued
    tv[18] = v(24'h010203, 1, 0, 0, '0, '0);
    tv[19] = v(24'h040506, 0, 0, 1, mk(1, 0, 32'h06010203), '0);
    tv[20] = v(24'h070809, 0, 1, 1, mk(0, 1, 32'h08090405), '0);
    tv[21] = v(24'h0A0B0C, 0, 0, 0, '0, '0);
    tv[22] = v(24'h0D0E0F, 1, 1, 2, mk(0, 1, 32'h000A0B0C), mk(1, 1, 32'h000D0E0F));

    // reset values
    #3;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("tkeep", tkeep, 4'hF);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);

    // aligned frame, no backpressure
    tready = 1'b1;
    for (int i = 0; i <= 7; i++) send_vec(i);
    idle();
    check_output("aligned");
    chk("aligned_misalign", misalign, 0);

    // backpressure: stall 10 cycles under continuous valid
    do_reset();
    tready = 1'b0;
    fork
      begin
        for (int i = 0; i <= 7; i++) send_vec(i);
        idle();
      end
      begin
        repeat (10) @(negedge clk);
        #1;
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_tvalid", tvalid, 1);
        tready = 1'b1;
      end
    join
    check_output("backpressure");

    // misaligned eol
    do_reset();
    for (int i = 8; i <= 13; i++) send_vec(i);
    idle();
    check_output("mis_eol");
    chk("mis_eol_flag", misalign, 1);

    // misaligned sof
    do_reset();
    for (int i = 14; i <= 17; i++) send_vec(i);
    idle();
    check_output("mis_sof");
    chk("mis_sof_flag", misalign, 1);

    // double push
    do_reset();
    tready = 1'b0;
    for (int i = 18; i <= 21; i++) send_vec(i);
    #1;
    chk("dbl_ready_before", in_ready, 1);
    chk("dbl_tvalid_before", tvalid, 1);
    send_vec(22);
    idle();
    #1;
    chk("dbl_ready_after", in_ready, 0);
    tready = 1'b1;
    check_output("double");

    // async reset with three words queued
    do_reset();
    tready = 1'b0;
    for (int i = 0; i <= 3; i++) send_vec(i);
    idle();
    #1;
    chk("ar_tvalid_before", tvalid, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_tvalid_async", tvalid, 0);
    chk("ar_tdata_async", tdata, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tready = 1'b1;
    @(negedge clk);
    cap_q.delete();
    exp_q.delete();
    for (int i = 0; i <= 7; i++) send_vec(i);
    idle();
    check_output("after_reset");
    chk("ar_misalign", misalign, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
